sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Synchronous initiator for the team's asynchronous SRAM block (10-bit address, 8-bit bidirectional data, read_write_select, chip_select).
- Converts a clocked valid/ready request interface into correctly sequenced SRAM bus cycles.
- Owns bus turnaround: it never drives data while the SRAM may be driving.
- Sits between on-chip masters and the SRAM instance; it replaces bench-style direct pin wiggling.

Parameters:
ADDR_W, 10, SRAM address width
DATA_W, 8, SRAM data width
WR_CYCLES, 2, clocks cs/rws are held asserted for a write (>=1)
RD_CYCLES, 2, clocks cs is held asserted before read data is sampled (>=1)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse, read data valid
rsp_rdata  out  DATA_W  captured read data
busy  out  1  high whenever state != IDLE
sram_address  out  ADDR_W  to SRAM address
sram_data_io  inout  DATA_W  to SRAM data_io
sram_rws  out  1  to SRAM read_write_select (1=write, 0=read)
sram_cs  out  1  to SRAM chip_select (active high)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values: state=IDLE, req_ready=0 during reset and 1 in the first IDLE cycle after, rsp_valid=0, rsp_rdata=0, busy=0, sram_cs=0, sram_rws=0, sram_address=0, sram_data_io=Z.
- Bus ownership: the controller drives sram_data_io only when sram_rws=1 and sram_cs=1. Otherwise sram_data_io is Z.
- All SRAM-side outputs are registered. No combinational path from req_* to sram_*.
- Accept: a request is taken on a rising edge where req_valid && req_ready. req_ready=1 only in IDLE. addr/wdata/write are latched on acceptance.
- IDLE: cs=0, rws=0, Z. On accept, go to WRITE or READ and load cnt = (WR|RD)_CYCLES-1.
- WRITE: cs=1, rws=1, address=latched addr, data driven = latched wdata. cnt decrements each cycle. At cnt==0, go to TURN.
- READ: cs=1, rws=0, address=latched addr, Z. cnt decrements each cycle. On the edge where cnt==0, capture sram_data_io into rsp_rdata and go to TURN.
- TURN: exactly 1 cycle. cs=0, rws=0, Z, address held. rsp_valid=1 during TURN only if the completing op was a read. Next state is IDLE.
- Read latency: accept edge to rsp_valid high = RD_CYCLES+1 clocks.
- Throughput: one transaction per (CYCLES+2) clocks, counting IDLE.
- rsp_rdata holds its value until the next read capture.
- Counter width: clog2(max(WR_CYCLES,RD_CYCLES))+1. Never wraps below 0.
- Address: full ADDR_W range, 0..2^ADDR_W-1. No increment logic and no wrap handling inside the block.
- req_valid while busy: ignored, no back-pressure violation. The request must be held by the master until accepted.
- Reset mid-operation: next edge forces all reset values. The aborted write may be partial. No rsp_valid is issued for an aborted read.
- X on req_* while req_valid=0 must not propagate to sram_* outputs.

Decomposition:
- sram_ctrl_pkg holds the state enum (IDLE, WRITE, READ, TURN), the default ADDR_W/DATA_W/cycle constants, and a counter-width function.
- No sub-module. The FSM, counter and tristate driver stay flat in sram_ctrl.
- The existing SRAM model is instantiated only in the verification bench.

Test Plan:
- Write then read: write addr 0x005 data 0x0A, then read 0x005. sram_rws=1 and sram_cs=1 for exactly 2 clocks. rsp_valid pulses 3 clocks after read accept with rsp_rdata=0x0A.
- Full sweep: write data (2*i)&0xFF to addr i for i=0..1023, then read all. Every rsp_rdata matches; addr 0x3FF returns 0xFE.
- Back-to-back: req_valid held high with alternating write/read to addr 0x100. req_ready is high only in IDLE. Transactions are 4 clocks apart. A TURN cycle with cs=0 and data_io=Z occurs between every pair.
- Reset mid-read: assert rst_n=0 in the second READ cycle. Next edge gives cs=0, rws=0, Z, rsp_valid never pulses, busy=0.
- Contention check: bench monitor asserts the controller never drives data_io while sram_rws=0, across all scenarios and for WR_CYCLES=RD_CYCLES=1 and 4.
- Ignored request: pulse req_valid in the WRITE state with addr 0x2AA. The request is not accepted, and the SRAM at 0x2AA is unchanged (read back original 0x54).

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared definitions for the synchronous SRAM initiator:
//   state_t      - controller FSM state encoding
//   *_DEF        - default bus widths and access lengths
//   cnt_width()  - width of the access-length down-counter
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 8;
  localparam int WR_CYCLES_DEF = 2;
  localparam int RD_CYCLES_DEF = 2;

  // The counter holds at most max(WR,RD)-1; the extra bit keeps the
  // width at least 1 even when both access lengths are 1.
  function automatic int cnt_width(input int wr_cycles, input int rd_cycles);
    int longest;
    longest = (wr_cycles > rd_cycles) ? wr_cycles : rd_cycles;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl
// Converts a valid/ready request stream into sequenced bus cycles for the
// asynchronous SRAM block and owns data-bus turnaround.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   req_valid/req_ready   - request handshake (ready only in IDLE)
//   req_write             - 1 = write, 0 = read
//   req_addr, req_wdata   - latched when the request is accepted
//   rsp_valid, rsp_rdata  - one-cycle read-data pulse, data held until next read
//   busy                  - controller is not in IDLE
//   sram_address, sram_data_io, sram_rws, sram_cs - SRAM pins (all registered)
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF,
  parameter int RD_CYCLES = RD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_address,
  inout  wire  [DATA_W-1:0] sram_data_io,
  output logic              sram_rws,
  output logic              sram_cs
);

  localparam int              CNT_W   = cnt_width(WR_CYCLES, RD_CYCLES);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                cs_r, rws_r, drive_r, rsp_valid_r, ready_r, busy_r;
  logic                cs_nxt_s, rws_nxt_s, drive_nxt_s, rsp_valid_nxt_s;
  logic                ready_nxt_s, busy_nxt_s;
  logic                accept_s, capture_s;

  // Handshake uses the registered ready, so req_* never reaches the pins
  // combinationally; req_write/addr/wdata are only looked at on accept.
  assign accept_s  = req_valid && ready_r;
  assign capture_s = (state_r == READ) && (cnt_r == CNT_ZERO);

  // State register and access-length counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_write) begin
            state_nxt_s = WRITE;
            cnt_nxt_s   = WR_LOAD;
          end else begin
            state_nxt_s = READ;
            cnt_nxt_s   = RD_LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE, READ: begin
        // Stop at zero rather than wrapping; leaving for TURN ends the access.
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = TURN;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      TURN: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state, so the registered pins line up
  // exactly with the state they belong to.
  always_comb begin
    cs_nxt_s        = 1'b0;
    rws_nxt_s       = 1'b0;
    drive_nxt_s     = 1'b0;
    ready_nxt_s     = 1'b0;
    busy_nxt_s      = 1'b1;
    rsp_valid_nxt_s = (state_r == READ) && (state_nxt_s == TURN);
    case (state_nxt_s)
      IDLE: begin
        ready_nxt_s = 1'b1;
        busy_nxt_s  = 1'b0;
      end
      WRITE: begin
        cs_nxt_s    = 1'b1;
        rws_nxt_s   = 1'b1;
        drive_nxt_s = 1'b1;
      end
      READ: begin
        cs_nxt_s = 1'b1;
      end
      TURN: begin
        cs_nxt_s = 1'b0;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Output, request-latch and read-capture registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_r        <= 1'b0;
      rws_r       <= 1'b0;
      drive_r     <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
    end else begin
      cs_r        <= cs_nxt_s;
      rws_r       <= rws_nxt_s;
      drive_r     <= drive_nxt_s;
      ready_r     <= ready_nxt_s;
      busy_r      <= busy_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      if (accept_s) begin
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end else begin
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
      if (capture_s) begin
        rdata_r <= sram_data_io;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // drive_r is set only for WRITE, which is exactly when cs and rws are both
  // high, so the bus is released during READ, TURN and IDLE.
  assign sram_data_io = drive_r ? wdata_r : {DATA_W{1'bz}};
  assign sram_address = addr_r;
  assign sram_cs      = cs_r;
  assign sram_rws     = rws_r;
  assign req_ready    = ready_r;
  assign busy         = busy_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_rdata    = rdata_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl
// Directed bench for sram_ctrl. Three controllers share clk/rst_n: the
// default build (2/2 cycles) plus 1/1 and 4/4 builds. Each has its own
// behavioural SRAM; the bus is checked every cycle on all three.
module tb_sram_ctrl;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_write, req_ready, rsp_valid, busy, sram_rws, sram_cs;
  logic [9:0]  req_addr, sram_address;
  logic [7:0]  req_wdata, rsp_rdata;
  wire  [7:0]  sram_data_io;

  logic        c1_req_valid, c1_req_write, c1_req_ready, c1_rsp_valid, c1_busy, c1_rws, c1_cs;
  logic [9:0]  c1_req_addr, c1_address;
  logic [7:0]  c1_req_wdata, c1_rsp_rdata;
  wire  [7:0]  c1_data_io;

  logic        c4_req_valid, c4_req_write, c4_req_ready, c4_rsp_valid, c4_busy, c4_rws, c4_cs;
  logic [9:0]  c4_req_addr, c4_address;
  logic [7:0]  c4_req_wdata, c4_rsp_rdata;
  wire  [7:0]  c4_data_io;

  logic [7:0]  mem0 [1024];
  logic [7:0]  mem1 [1024];
  logic [7:0]  mem4 [1024];

  int checks;
  int errors;

  sram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sram_address(sram_address), .sram_data_io(sram_data_io),
    .sram_rws(sram_rws), .sram_cs(sram_cs)
  );

  sram_ctrl #(.WR_CYCLES(1), .RD_CYCLES(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(c1_req_valid), .req_ready(c1_req_ready), .req_write(c1_req_write),
    .req_addr(c1_req_addr), .req_wdata(c1_req_wdata),
    .rsp_valid(c1_rsp_valid), .rsp_rdata(c1_rsp_rdata), .busy(c1_busy),
    .sram_address(c1_address), .sram_data_io(c1_data_io),
    .sram_rws(c1_rws), .sram_cs(c1_cs)
  );

  sram_ctrl #(.WR_CYCLES(4), .RD_CYCLES(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(c4_req_valid), .req_ready(c4_req_ready), .req_write(c4_req_write),
    .req_addr(c4_req_addr), .req_wdata(c4_req_wdata),
    .rsp_valid(c4_rsp_valid), .rsp_rdata(c4_rsp_rdata), .busy(c4_busy),
    .sram_address(c4_address), .sram_data_io(c4_data_io),
    .sram_rws(c4_rws), .sram_cs(c4_cs)
  );

  // Behavioural SRAMs: drive the bus while selected for read, store on write.
  assign sram_data_io = (sram_cs && !sram_rws) ? mem0[sram_address] : 8'hzz;
  assign c1_data_io   = (c1_cs && !c1_rws)     ? mem1[c1_address]   : 8'hzz;
  assign c4_data_io   = (c4_cs && !c4_rws)     ? mem4[c4_address]   : 8'hzz;

  always @(posedge clk) begin
    if (sram_cs && sram_rws) mem0[sram_address] <= sram_data_io;
    if (c1_cs && c1_rws)     mem1[c1_address]   <= c1_data_io;
    if (c4_cs && c4_rws)     mem4[c4_address]   <= c4_data_io;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_ready(input int s);
    case (s)
      0: return req_ready;
      1: return c1_req_ready;
      default: return c4_req_ready;
    endcase
  endfunction

  function automatic logic f_cs(input int s);
    case (s)
      0: return sram_cs;
      1: return c1_cs;
      default: return c4_cs;
    endcase
  endfunction

  function automatic logic f_rws(input int s);
    case (s)
      0: return sram_rws;
      1: return c1_rws;
      default: return c4_rws;
    endcase
  endfunction

  function automatic logic f_rspv(input int s);
    case (s)
      0: return rsp_valid;
      1: return c1_rsp_valid;
      default: return c4_rsp_valid;
    endcase
  endfunction

  function automatic logic [7:0] f_rdata(input int s);
    case (s)
      0: return rsp_rdata;
      1: return c1_rsp_rdata;
      default: return c4_rsp_rdata;
    endcase
  endfunction

  function automatic logic [7:0] f_dio(input int s);
    case (s)
      0: return sram_data_io;
      1: return c1_data_io;
      default: return c4_data_io;
    endcase
  endfunction

  function automatic logic [7:0] f_mem(input int s);
    case (s)
      0: return mem0[sram_address];
      1: return mem1[c1_address];
      default: return mem4[c4_address];
    endcase
  endfunction

  task automatic drive(input int s, input logic v, input logic w,
                       input logic [9:0] a, input logic [7:0] d);
    case (s)
      0: begin req_valid = v; req_write = w; req_addr = a; req_wdata = d; end
      1: begin c1_req_valid = v; c1_req_write = w; c1_req_addr = a; c1_req_wdata = d; end
      default: begin c4_req_valid = v; c4_req_write = w; c4_req_addr = a; c4_req_wdata = d; end
    endcase
  endtask

  // Advance one clock, then check bus rules on every controller:
  // rws never high without cs, and read data is not corrupted by a second driver.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rws_without_cs", {31'd0, f_rws(s) & ~f_cs(s)}, 32'd0);
      if (f_cs(s) && !f_rws(s))
        chk("read_contention", {24'd0, f_dio(s)}, {24'd0, f_mem(s)});
    end
  endtask

  // One complete transaction. cs_cyc counts cycles with cs high; lat is the
  // number of edges from the accept edge to the edge at which rsp_valid is
  // seen high (0 = never, -1 = more than one pulse).
  task automatic xfer(input int s, input logic w, input logic [9:0] a, input logic [7:0] d,
                      output int cs_cyc, output int lat, output logic [7:0] rd);
    int n;
    int k;
    drive(s, 1'b1, w, a, d);
    n = 0;
    while (!f_ready(s) && n < 50) begin
      tick();
      n++;
    end
    chk("accept_wait", {31'd0, n < 50}, 32'd1);
    tick();
    drive(s, 1'b0, 1'b0, 10'h000, 8'h00);
    cs_cyc = 0;
    lat    = 0;
    rd     = 8'h00;
    k      = 0;
    while (k < 50) begin
      if (f_cs(s)) cs_cyc++;
      if (f_rspv(s)) begin
        lat = (lat == 0) ? k + 1 : -1;
        rd  = f_rdata(s);
      end
      if (f_ready(s)) break;
      tick();
      k++;
    end
    chk("idle_wait", {31'd0, k < 50}, 32'd1);
  endtask

  initial begin
    int cs_cyc, lat, n, last, nacc, nturn, nrsp;
    logic [7:0] rd, exp_rd;
    logic saw_rsp;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 10'h000, 8'h00);

    // Reset values.
    tick();
    tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cs", {31'd0, sram_cs}, 32'd0);
    chk("rst_rws", {31'd0, sram_rws}, 32'd0);
    chk("rst_addr", {22'd0, sram_address}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Write 0x0A to 0x005, read it back.
    xfer(0, 1'b1, 10'h005, 8'h0A, cs_cyc, lat, rd);
    chk("wr_cs_cycles", cs_cyc, 32'd2);
    chk("wr_no_rsp", lat, 32'd0);
    xfer(0, 1'b0, 10'h005, 8'h00, cs_cyc, lat, rd);
    chk("rd_cs_cycles", cs_cyc, 32'd2);
    chk("rd_latency", lat, 32'd3);
    chk("rd_data", {24'd0, rd}, 32'h0A);

    // Unknowns on req_* while req_valid=0 must not reach the pins.
    drive(0, 1'b0, 1'bx, {10{1'bx}}, {8{1'bx}});
    tick();
    tick();
    chk("x_addr_held", {22'd0, sram_address}, 32'h005);
    chk("x_cs", {31'd0, sram_cs}, 32'd0);
    chk("x_busy", {31'd0, busy}, 32'd0);
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00);

    // Full address sweep.
    for (int i = 0; i < 1024; i++) begin
      xfer(0, 1'b1, 10'(i), 8'((2 * i) & 8'hFF), cs_cyc, lat, rd);
    end
    for (int i = 0; i < 1024; i++) begin
      xfer(0, 1'b0, 10'(i), 8'h00, cs_cyc, lat, rd);
      chk("sweep_rd", {24'd0, rd}, 32'((2 * i) & 8'hFF));
    end
    xfer(0, 1'b0, 10'h3FF, 8'h00, cs_cyc, lat, rd);
    chk("rd_3ff", {24'd0, rd}, 32'hFE);

    // Back-to-back alternating write/read to 0x100 with req_valid held high.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 10'h100;
    req_wdata = 8'h77;
    exp_rd = 8'h00;
    last = 0; nacc = 0; nturn = 0; nrsp = 0;
    for (int i = 0; i < 24; i++) begin
      n = int'(req_ready);
      chk("b2b_ready_only_idle", {31'd0, req_ready}, {31'd0, ~busy});
      tick();
      if (n == 1) begin
        if (nacc > 0) chk("b2b_spacing", i - last, 32'd4);
        last = i;
        nacc++;
        if (req_write) begin
          exp_rd    = req_wdata;
          req_wdata = req_wdata + 8'h01;
        end
        req_write = ~req_write;
      end
      if (busy && !sram_cs) nturn++;
      if (rsp_valid) begin
        chk("b2b_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rd});
        nrsp++;
      end
    end
    req_valid = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      tick();
      if (busy && !sram_cs) nturn++;
      if (rsp_valid) nrsp++;
      n++;
    end
    chk("b2b_accepts", nacc, 32'd6);
    chk("b2b_turns", nturn, 32'd6);
    chk("b2b_rsps", nrsp, 32'd3);

    // Request pulsed during WRITE is ignored.
    drive(0, 1'b1, 1'b1, 10'h001, 8'hC3);
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    drive(0, 1'b1, 1'b1, 10'h2AA, 8'hFF);
    chk("ign_ready_low", {31'd0, req_ready}, 32'd0);
    tick();
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00);
    chk("ign_addr_kept", {22'd0, sram_address}, 32'h001);
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk("ign_not_started", {31'd0, busy}, 32'd0);
    xfer(0, 1'b0, 10'h2AA, 8'h00, cs_cyc, lat, rd);
    chk("ign_mem_unchanged", {24'd0, rd}, 32'h54);
    xfer(0, 1'b0, 10'h001, 8'h00, cs_cyc, lat, rd);
    chk("ign_real_write", {24'd0, rd}, 32'hC3);

    // Reset asserted in the second READ cycle of a read from 0x010.
    drive(0, 1'b1, 1'b0, 10'h010, 8'h00);
    tick();
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00);
    tick();
    chk("mid_rd_cs", {31'd0, sram_cs}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_cs", {31'd0, sram_cs}, 32'd0);
    chk("mid_rst_rws", {31'd0, sram_rws}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("mid_rst_addr", {22'd0, sram_address}, 32'd0);
    rst_n = 1'b1;
    saw_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("mid_rst_no_rsp", {31'd0, saw_rsp}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);

    // Single-cycle and four-cycle builds.
    xfer(1, 1'b1, 10'h007, 8'h33, cs_cyc, lat, rd);
    chk("c1_wr_cs_cycles", cs_cyc, 32'd1);
    xfer(1, 1'b0, 10'h007, 8'h00, cs_cyc, lat, rd);
    chk("c1_rd_latency", lat, 32'd2);
    chk("c1_rd_data", {24'd0, rd}, 32'h33);
    xfer(2, 1'b1, 10'h3C5, 8'hC4, cs_cyc, lat, rd);
    chk("c4_wr_cs_cycles", cs_cyc, 32'd4);
    xfer(2, 1'b0, 10'h3C5, 8'h00, cs_cyc, lat, rd);
    chk("c4_rd_cs_cycles", cs_cyc, 32'd4);
    chk("c4_rd_latency", lat, 32'd5);
    chk("c4_rd_data", {24'd0, rd}, 32'hC4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
